// File: rtl/sram_controller.sv
// sram_controller: data-memory back end for the five-stage ARM pipeline.
// Each 32-bit load/store is split into two halfword accesses on an
// external 16-bit asynchronous SRAM. Low half first, then high half.
// Each phase lasts WAIT_CYCLES cycles.
//
// Optional feature macro: SRAM_LAST_READ_CACHE_EN
//   When defined, adds a single-entry last-read buffer (17-bit tag + valid).
//   A repeated read of the last word completes in IDLE with no SRAM activity.
//
// Parameters:
//   WAIT_CYCLES  cycles per halfword access (legal range 2..15)
//   ADDR_BASE    byte address of data memory word 0
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   wr_en       store request from the memory stage
//   rd_en       load request from the memory stage (a write wins if both are set)
//   address     byte address (ALU result)
//   write_data  store data
//   read_data   registered load result; holds the last completed read
//   ready       high when no access is pending (combinational)
//   SRAM_DQ     SRAM data bus, driven only during write phases
//   SRAM_ADDR   SRAM halfword address (registered)
//   SRAM_WE_N   write strobe, active-low (registered)
//   SRAM_OE_N   output enable, active-low (registered)
//   SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  tied low
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);
    // WE_N for the following cycle goes high once the counter reaches this
    // value, so the final cycle of each write phase holds data with WE_N=1.
    localparam logic [3:0] LAST_WE  = 4'(WAIT_CYCLES - 2);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        is_wr_q;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic [31:0] read_data_q;
    logic [17:0] sram_addr_q;
    logic        we_n_q;
    logic        oe_n_q;

    logic [16:0] word_d;
    logic        req;
    logic        hit;
    logic        start;

    assign word_d = 17'((address - ADDR_BASE) >> 2);
    assign req    = wr_en | rd_en;

`ifdef SRAM_LAST_READ_CACHE_EN
    logic [16:0] tag_q;
    logic        valid_q;

    assign hit = rd_en & ~wr_en & valid_q & (tag_q == word_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else if (state_q == IDLE && wr_en) begin
            valid_q <= 1'b0;
        end else if (state_q == HIGH && cnt_q == LAST_CNT && !is_wr_q) begin
            tag_q   <= word_q;
            valid_q <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    assign start = req & ~hit;

    assign ready = (state_q == DONE) || (state_q == IDLE && (!req || hit));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        is_wr_q     <= wr_en;
                        word_q      <= word_d;
                        wdata_q     <= write_data;
                        sram_addr_q <= {word_d, 1'b0};
                        we_n_q      <= ~wr_en;
                        oe_n_q      <= wr_en;
                        state_q     <= LOW;
                    end
                end
                LOW: begin
                    if (cnt_q == LAST_CNT) begin
                        if (!is_wr_q) read_data_q[15:0] <= SRAM_DQ;
                        cnt_q       <= '0;
                        sram_addr_q <= {word_q, 1'b1};
                        we_n_q      <= ~is_wr_q;
                        oe_n_q      <= is_wr_q;
                        state_q     <= HIGH;
                    end else begin
                        cnt_q  <= cnt_q + 4'd1;
                        we_n_q <= is_wr_q ? (cnt_q >= LAST_WE) : 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt_q == LAST_CNT) begin
                        if (!is_wr_q) read_data_q[31:16] <= SRAM_DQ;
                        cnt_q   <= '0;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q  <= cnt_q + 4'd1;
                        we_n_q <= is_wr_q ? (cnt_q >= LAST_WE) : 1'b1;
                    end
                end
                DONE: begin
                    // The request still present here is the one just served.
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign SRAM_DQ = (is_wr_q && state_q == LOW)  ? wdata_q[15:0]  :
                     (is_wr_q && state_q == HIGH) ? wdata_q[31:16] : 'z;

    assign read_data = read_data_q;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural async SRAM.
module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ce_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    int n_vec = 0;
    int n_err = 0;

    int          exp_lat_q[$];
    logic [31:0] exp_rd_q[$];
    bit          chk_rd_q[$];

    int          we_lo, we_hi;
    logic [15:0] dq_lo, dq_hi;
    logic [17:0] addr_lo, addr_hi;

`ifdef SRAM_LAST_READ_CACHE_EN
    localparam int HIT_LAT = 0;
`else
    localparam int HIT_LAT = 11;
`endif

    sram_controller #(.WAIT_CYCLES(5), .ADDR_BASE(32'd1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_OE_N  (sram_oe_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: drives the bus on reads, samples it on writes.
    logic [15:0] mem [0:63];
    initial for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[5:0]] : 16'hzzzz;
    always @(negedge clk) if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge. Cycle 0 is the request cycle in IDLE.
    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input int exp_lat,
                          input bit chk_rd, input logic [31:0] exp_rd);
        int lat;
        exp_lat_q.push_back(exp_lat);
        exp_rd_q.push_back(exp_rd);
        chk_rd_q.push_back(chk_rd);
        wr_en = w; rd_en = r; address = a; write_data = d;
        we_lo = 0; we_hi = 0; lat = -1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!sram_we_n) begin
                if (sram_addr[0]) begin we_hi++; dq_hi = sram_dq; addr_hi = sram_addr; end
                else              begin we_lo++; dq_lo = sram_dq; addr_lo = sram_addr; end
            end
            if (ready) begin lat = c; break; end
            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        chk("latency", lat, exp_lat_q.pop_front());
        if (chk_rd_q.pop_front()) chk("read_data", read_data, exp_rd_q.pop_front());
        else void'(exp_rd_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        #12;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        chk("rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
        chk("rst_addr", {14'b0, sram_addr}, 32'd0);
        @(negedge clk); rst = 1'b0; @(negedge clk);

        // Store 0xDEADBEEF at 1032 -> halfword addresses 4 and 5.
        access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 11, 1'b1, 32'h0);
        chk("st_we_lo_cycles", we_lo, 32'd4);
        chk("st_we_hi_cycles", we_hi, 32'd4);
        chk("st_addr_lo", {14'b0, addr_lo}, 32'd4);
        chk("st_addr_hi", {14'b0, addr_hi}, 32'd5);
        chk("st_dq_lo", {16'b0, dq_lo}, 32'h0000BEEF);
        chk("st_dq_hi", {16'b0, dq_hi}, 32'h0000DEAD);
        chk("st_mem4", {16'b0, mem[4]}, 32'h0000BEEF);
        chk("st_mem5", {16'b0, mem[5]}, 32'h0000DEAD);

        // Load back.
        access(1'b0, 1'b1, 32'd1032, 32'h0, 11, 1'b1, 32'hDEADBEEF);

        // Simultaneous requests: write wins, read_data untouched.
        access(1'b1, 1'b1, 32'd1024, 32'h12345678, 11, 1'b1, 32'hDEADBEEF);
        chk("sim_mem0", {16'b0, mem[0]}, 32'h00005678);
        chk("sim_mem1", {16'b0, mem[1]}, 32'h00001234);
        access(1'b0, 1'b1, 32'd1024, 32'h0, 11, 1'b1, 32'h12345678);

        // Reset in cycle 6 of a read (first cycle of the high phase).
        wr_en = 1'b0; rd_en = 1'b1; address = 32'd1032;
        repeat (6) @(negedge clk);
        #1;
        chk("mid_oe_active", {31'b0, sram_oe_n}, 32'd0);
        rst = 1'b1; rd_en = 1'b0;
        #1;
        chk("mid_rst_ready", {31'b0, ready}, 32'd1);
        chk("mid_rst_rdata", read_data, 32'h0);
        chk("mid_rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
        chk("mid_rst_we_n", {31'b0, sram_we_n}, 32'd1);
        @(negedge clk); rst = 1'b0; @(negedge clk);
        access(1'b0, 1'b1, 32'd1032, 32'h0, 11, 1'b1, 32'hDEADBEEF);

        // Last-read buffer sequence: read, read, write, read.
        access(1'b0, 1'b1, 32'd1032, 32'h0, HIT_LAT, 1'b1, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 11, 1'b1, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1032, 32'h0, 11, 1'b1, 32'hCAFEF00D);
        access(1'b0, 1'b1, 32'd1024, 32'h0, 11, 1'b1, 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
